// File: rtl/sram_sprite_fetcher.sv
// SRAM image-region reader. Accepts a span command over a packed,
// row-major image, fetches one SRAM word at a time and streams the
// unpacked pixels out with valid/ready flow control. It supports
// horizontal mirroring and flags pixels equal to the transparency key.
module sram_sprite_fetcher #(
  parameter int SRAM_ADDR_W = 20,
  parameter int SRAM_DATA_W = 16,
  parameter int PIXEL_W     = 4,
  parameter int IMG_W_W     = 11,
  parameter int IMG_V_W     = 10,
  parameter int READ_LAT    = 1,
  parameter int TRANS_KEY   = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [SRAM_ADDR_W-1:0] i_cmd_base,
  input  logic [IMG_W_W-1:0]     i_cmd_img_w,
  input  logic [IMG_V_W-1:0]     i_cmd_y,
  input  logic [IMG_W_W-1:0]     i_cmd_x0,
  input  logic [IMG_W_W-1:0]     i_cmd_len,
  input  logic                   i_cmd_mirror,
  output logic                   o_sram_req,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  input  logic                   i_sram_gnt,
  input  logic [SRAM_DATA_W-1:0] i_sram_rdata,
  output logic                   o_pix_valid,
  input  logic                   i_pix_ready,
  output logic [PIXEL_W-1:0]     o_pix_data,
  output logic                   o_pix_transp,
  output logic                   o_pix_last,
  output logic                   o_done
);

  // Pixels per word and the index width that never truncates y*img_w + col.
  localparam int PPW   = SRAM_DATA_W / PIXEL_W;
  localparam int SUB_W = $clog2(PPW);
  localparam int IDX_W = IMG_V_W + IMG_W_W + 1;
  localparam int COL_W = IMG_W_W + 1;
  localparam int LAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_REQ,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  // Latched command fields.
  logic [SRAM_ADDR_W-1:0]  r_base;
  logic [IMG_W_W-1:0]      r_img_w;
  logic [IMG_V_W-1:0]      r_y;
  logic [IMG_W_W-1:0]      r_x0;
  logic                    r_mirror;

  // Walk state: pixels still to emit, current word address, pixel slot.
  logic [IMG_W_W-1:0]      r_remain;
  logic [SRAM_ADDR_W-1:0]  r_addr;
  logic [SUB_W-1:0]        r_sub;
  logic [SRAM_DATA_W-1:0]  r_word;
  logic [LAT_W-1:0]        r_lat_cnt;
  logic                    r_done;

  logic                    w_cmd_fire;
  logic                    w_pix_fire;
  logic                    w_last;
  logic                    w_cross;
  logic                    w_lat_hit;
  logic [COL_W-1:0]        w_col;
  logic [IDX_W-1:0]        w_idx;
  logic [SRAM_ADDR_W-1:0]  w_word_addr;
  logic [PIXEL_W-1:0]      w_pix;

  assign w_cmd_fire = i_cmd_valid && (r_state == S_IDLE);
  assign w_pix_fire = (r_state == S_EMIT) && i_pix_ready;
  assign w_last     = (r_remain == IMG_W_W'(1));
  assign w_lat_hit  = (r_lat_cnt == '0);
  // The word is exhausted once the slot about to leave is the edge slot.
  assign w_cross    = r_mirror ? (r_sub == '0) : (r_sub == SUB_W'(PPW - 1));

  // Starting column: leftmost for a normal span, rightmost when mirrored.
  assign w_col = r_mirror ? (COL_W'(r_x0) + COL_W'(r_remain) - COL_W'(1))
                          : COL_W'(r_x0);

  // Linear pixel index at full width, then word address with wrap-around.
  assign w_idx       = IDX_W'(r_y) * IDX_W'(r_img_w) + IDX_W'(w_col);
  assign w_word_addr = r_base + SRAM_ADDR_W'(w_idx >> SUB_W);

  // Select the current pixel; slot 0 sits in the most significant bits.
  always_comb begin
    // NOTE: a default before the loop keeps this purely combinational; any
    // path that left w_pix unassigned would infer a latch.
    w_pix = '0;
    for (int k = 0; k < PPW; k++) begin
      if (r_sub == SUB_W'(k)) begin
        w_pix = r_word[SRAM_DATA_W-1-k*PIXEL_W -: PIXEL_W];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire && (i_cmd_len != '0)) begin
          w_next = S_CALC;
        end
      end
      S_CALC: w_next = S_REQ;
      S_REQ: begin
        if (i_sram_gnt) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_lat_hit) begin
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_pix_fire) begin
          if (w_last) begin
            w_next = S_IDLE;
          end else if (w_cross) begin
            w_next = S_REQ;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; pixel outputs read as zero whenever nothing is valid.
  always_comb begin
    o_cmd_ready  = (r_state == S_IDLE);
    o_sram_req   = (r_state == S_REQ);
    o_pix_valid  = (r_state == S_EMIT);
    o_pix_data   = '0;
    o_pix_transp = 1'b0;
    o_pix_last   = 1'b0;
    if (r_state == S_EMIT) begin
      o_pix_data   = w_pix;
      o_pix_transp = (w_pix == PIXEL_W'(TRANS_KEY));
      o_pix_last   = w_last;
    end
  end

  assign o_sram_addr = r_addr;
  assign o_done      = r_done;

  // Command capture, address/slot walk, read-latency count and word buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_base    <= '0;
      r_img_w   <= '0;
      r_y       <= '0;
      r_x0      <= '0;
      r_mirror  <= 1'b0;
      r_remain  <= '0;
      r_addr    <= '0;
      r_sub     <= '0;
      r_word    <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_base   <= i_cmd_base;
        r_img_w  <= i_cmd_img_w;
        r_y      <= i_cmd_y;
        r_x0     <= i_cmd_x0;
        r_mirror <= i_cmd_mirror;
        r_remain <= i_cmd_len;
      end

      if (r_state == S_CALC) begin
        r_addr <= w_word_addr;
        r_sub  <= w_idx[SUB_W-1:0];
      end

      // Count from the grant cycle so capture lands exactly READ_LAT later.
      if ((r_state == S_REQ) && i_sram_gnt) begin
        r_lat_cnt <= LAT_W'(READ_LAT - 1);
      end else if ((r_state == S_WAIT) && !w_lat_hit) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end

      if ((r_state == S_WAIT) && w_lat_hit) begin
        r_word <= i_sram_rdata;
      end

      if (w_pix_fire) begin
        r_remain <= r_remain - IMG_W_W'(1);
        r_sub    <= r_mirror ? (r_sub - SUB_W'(1)) : (r_sub + SUB_W'(1));
        if (w_cross && !w_last) begin
          r_addr <= r_mirror ? (r_addr - SRAM_ADDR_W'(1))
                             : (r_addr + SRAM_ADDR_W'(1));
        end
      end
    end
  end

  // Completion pulse: after an empty command or the final pixel handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_cmd_fire && (i_cmd_len == '0)) || (w_pix_fire && w_last);
    end
  end

endmodule

// File: tb/tb_sram_sprite_fetcher.sv
// Directed bench for sram_sprite_fetcher: a small SRAM responder, a
// reference pixel/address model feeding scoreboard queues, and monitors
// that compare DUT traffic against those queues.
module tb_sram_sprite_fetcher;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [19:0] i_cmd_base = '0;
  logic [10:0] i_cmd_img_w = '0;
  logic [9:0]  i_cmd_y = '0;
  logic [10:0] i_cmd_x0 = '0;
  logic [10:0] i_cmd_len = '0;
  logic        i_cmd_mirror = 1'b0;
  logic        o_sram_req;
  logic [19:0] o_sram_addr;
  logic        i_sram_gnt = 1'b0;
  logic [15:0] i_sram_rdata = '0;
  logic        o_pix_valid;
  logic        i_pix_ready = 1'b0;
  logic [3:0]  o_pix_data;
  logic        o_pix_transp;
  logic        o_pix_last;
  logic        o_done;

  sram_sprite_fetcher dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_base   (i_cmd_base),
    .i_cmd_img_w  (i_cmd_img_w),
    .i_cmd_y      (i_cmd_y),
    .i_cmd_x0     (i_cmd_x0),
    .i_cmd_len    (i_cmd_len),
    .i_cmd_mirror (i_cmd_mirror),
    .o_sram_req   (o_sram_req),
    .o_sram_addr  (o_sram_addr),
    .i_sram_gnt   (i_sram_gnt),
    .i_sram_rdata (i_sram_rdata),
    .o_pix_valid  (o_pix_valid),
    .i_pix_ready  (i_pix_ready),
    .o_pix_data   (o_pix_data),
    .o_pix_transp (o_pix_transp),
    .o_pix_last   (o_pix_last),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  exp_pix_q[$];
  logic [19:0] exp_addr_q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int first_valid_cyc = 0;
  int last_cyc = 0;
  int done_cyc = 0;
  int done_count = 0;
  int read_count = 0;
  int valid_count = 0;
  int pix_seen = 0;
  bit got_first = 1'b0;

  int gnt_delay = 0;
  int req_age = 0;
  bit granted = 1'b0;
  logic [19:0] gaddr = '0;
  int stall_at = -1;
  int stall_left = 0;
  bit ready_en = 1'b1;
  bit req_pending = 1'b0;
  logic [19:0] req_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM contents used by the directed cases; elsewhere a address-derived pattern.
  function automatic logic [15:0] mem_rd(input logic [19:0] a);
    case (a)
      20'h57E40: mem_rd = 16'h1234;
      20'h57E41: mem_rd = 16'h5678;
      20'h57E72: mem_rd = 16'hABCD;
      20'h57E73: mem_rd = 16'hEF01;
      20'h00100: mem_rd = 16'h0F00;
      default:   mem_rd = a[15:0] ^ 16'hA5A5;
    endcase
  endfunction

  // Reference model: expected pixel stream and word-read sequence.
  task automatic push_expect(input int base, input int img_w, input int y,
                             input int x0, input int len, input bit mirror);
    logic [19:0] wa;
    logic [19:0] prev_wa;
    logic [15:0] w;
    int col;
    int idx;
    int k;
    prev_wa = '0;
    for (int i = 0; i < len; i++) begin
      col = mirror ? (x0 + len - 1 - i) : (x0 + i);
      idx = y * img_w + col;
      wa  = 20'(base + (idx / 4));
      k   = idx % 4;
      w   = mem_rd(wa);
      if (i == 0 || wa != prev_wa) exp_addr_q.push_back(wa);
      prev_wa = wa;
      exp_pix_q.push_back(w[15-4*k -: 4]);
    end
  endtask

  // Responder: grant after gnt_delay request cycles, data one cycle after grant.
  always @(posedge clk) begin
    #1;
    i_sram_rdata = granted ? mem_rd(gaddr) : 16'hDEAD;
    if (o_sram_req) begin
      i_sram_gnt = (req_age >= gnt_delay);
      req_age++;
    end else begin
      i_sram_gnt = 1'b0;
      req_age = 0;
    end
    if (stall_left > 0) begin
      i_pix_ready = 1'b0;
      stall_left--;
    end else begin
      i_pix_ready = ready_en;
    end
  end

  // Monitor, sampled mid-cycle when all signals are settled.
  always @(negedge clk) begin
    cyc++;
    if (i_cmd_valid && o_cmd_ready) begin
      acc_cyc = cyc;
      got_first = 1'b0;
    end
    if (o_sram_req && req_pending) check("addr_stable", 32'(o_sram_addr), 32'(req_addr));
    req_pending = o_sram_req && !i_sram_gnt;
    req_addr = o_sram_addr;
    granted = o_sram_req && i_sram_gnt;
    gaddr = o_sram_addr;
    if (granted) begin
      read_count++;
      check("addr_expected", 32'(exp_addr_q.size() != 0), 32'(1));
      if (exp_addr_q.size() != 0) check("sram_addr", 32'(o_sram_addr), 32'(exp_addr_q.pop_front()));
    end
    if (o_pix_valid) begin
      valid_count++;
      if (!got_first) begin
        got_first = 1'b1;
        first_valid_cyc = cyc;
      end
    end
    if (o_pix_valid && i_pix_ready) begin
      check("pix_expected", 32'(exp_pix_q.size() != 0), 32'(1));
      if (exp_pix_q.size() != 0) begin
        logic [3:0] e;
        e = exp_pix_q.pop_front();
        check("pix_data", 32'(o_pix_data), 32'(e));
        check("pix_transp", 32'(o_pix_transp), 32'(e == 4'h0));
        check("pix_last", 32'(o_pix_last), 32'(exp_pix_q.size() == 0));
      end
      pix_seen++;
      last_cyc = cyc;
      if (pix_seen == stall_at) stall_left = 5;
    end else if (o_pix_valid && exp_pix_q.size() != 0) begin
      check("pix_hold", 32'(o_pix_data), 32'(exp_pix_q[0]));
      check("last_hold", 32'(o_pix_last), 32'(exp_pix_q.size() == 1));
    end
    if (o_done) begin
      done_cyc = cyc;
      done_count++;
    end
  end

  task automatic send_cmd(input logic [19:0] base, input logic [10:0] img_w,
                          input logic [9:0] y, input logic [10:0] x0,
                          input logic [10:0] len, input logic mirror);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    i_cmd_valid  = 1'b1;
    i_cmd_base   = base;
    i_cmd_img_w  = img_w;
    i_cmd_y      = y;
    i_cmd_x0     = x0;
    i_cmd_len    = len;
    i_cmd_mirror = mirror;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("cmd_accept", 32'(seen), 32'(1));
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    check(tag, 32'(seen), 32'(1));
    check("queues_drained", 32'(exp_pix_q.size() + exp_addr_q.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'(1));
    check({tag, "_req"},       32'(o_sram_req),  32'(0));
    check({tag, "_addr"},      32'(o_sram_addr), 32'(0));
    check({tag, "_valid"},     32'(o_pix_valid), 32'(0));
    check({tag, "_data"},      32'(o_pix_data),  32'(0));
    check({tag, "_transp"},    32'(o_pix_transp), 32'(0));
    check({tag, "_last"},      32'(o_pix_last),  32'(0));
    check({tag, "_done"},      32'(o_done),      32'(0));
  endtask

  initial begin
    int r0;
    int v0;
    int d0;
    bit reached;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;

    // 1: straight 8-pixel span across two words.
    push_expect(32'h57E40, 200, 0, 0, 8, 1'b0);
    r0 = read_count;
    send_cmd(20'h57E40, 11'd200, 10'd0, 11'd0, 11'd8, 1'b0);
    wait_done("t1_done");
    check("t1_reads", 32'(read_count - r0), 32'(2));
    check("t1_latency", 32'(first_valid_cyc - acc_cyc), 32'(4));
    check("t1_done_timing", 32'(done_cyc - last_cyc), 32'(1));

    // 2: mid-word start on row 1.
    push_expect(32'h57E40, 200, 1, 2, 3, 1'b0);
    r0 = read_count;
    send_cmd(20'h57E40, 11'd200, 10'd1, 11'd2, 11'd3, 1'b0);
    wait_done("t2_done");
    check("t2_reads", 32'(read_count - r0), 32'(2));

    // 3: mirrored span.
    push_expect(32'h57E40, 200, 0, 0, 8, 1'b1);
    r0 = read_count;
    send_cmd(20'h57E40, 11'd200, 10'd0, 11'd0, 11'd8, 1'b1);
    wait_done("t3_done");
    check("t3_reads", 32'(read_count - r0), 32'(2));
    check("t3_done_timing", 32'(done_cyc - last_cyc), 32'(1));

    // 4: consumer stall after pixel 3 and slow grants.
    gnt_delay = 3;
    pix_seen = 0;
    stall_at = 3;
    push_expect(32'h57E40, 200, 0, 0, 8, 1'b0);
    r0 = read_count;
    send_cmd(20'h57E40, 11'd200, 10'd0, 11'd0, 11'd8, 1'b0);
    wait_done("t4_done");
    check("t4_reads", 32'(read_count - r0), 32'(2));
    gnt_delay = 0;
    stall_at = -1;

    // 5a: empty span.
    r0 = read_count;
    v0 = valid_count;
    send_cmd(20'h57E40, 11'd200, 10'd0, 11'd0, 11'd0, 1'b0);
    wait_done("t5_done");
    check("t5_done_timing", 32'(done_cyc - acc_cyc), 32'(1));
    check("t5_no_reads", 32'(read_count - r0), 32'(0));
    check("t5_no_valid", 32'(valid_count - v0), 32'(0));

    // 5b: transparency flags on word 0x0F00.
    push_expect(32'h00100, 4, 0, 0, 4, 1'b0);
    send_cmd(20'h00100, 11'd4, 10'd0, 11'd0, 11'd4, 1'b0);
    wait_done("t5b_done");

    // 6: reset mid-EMIT, then a fresh command.
    pix_seen = 0;
    push_expect(32'h57E40, 200, 0, 0, 8, 1'b0);
    send_cmd(20'h57E40, 11'd200, 10'd0, 11'd0, 11'd8, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pix_seen >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("t6_reach_emit", 32'(reached), 32'(1));
    @(posedge clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("t6_after_reset");
    exp_pix_q.delete();
    exp_addr_q.delete();
    d0 = done_count;
    repeat (10) @(negedge clk);
    check("t6_no_done", 32'(done_count - d0), 32'(0));
    push_expect(32'h57E40, 200, 0, 0, 8, 1'b0);
    r0 = read_count;
    send_cmd(20'h57E40, 11'd200, 10'd0, 11'd0, 11'd8, 1'b0);
    wait_done("t6_fresh_done");
    check("t6_reads", 32'(read_count - r0), 32'(2));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
